pa_feeder: RTL and testbench

PA_FEEDER -- requirements
Module: pa_feeder

---
 rtl/pa_feeder.sv | 105 ++++++++++
 tb/tb_pa_feeder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pa_feeder.sv
// Vector-pair feeder: buffers {v, h, last} entries and releases them to the array in bursts.
// A burst starts once BURST_LEN entries or a last-flagged entry are buffered, and ends on the BURST_LEN-th pop or a last pop.
//
// state  | meaning
// IDLE   | buffer empty, nothing presented
// FILL   | entries buffered, waiting for a full burst or a last flag
// STREAM | head entry presented, data_rdy_o high, pops allowed
module pa_feeder #(
    parameter int SIZE_MAT   = 16,
    parameter int WIDTH_DATA = 16,
    parameter int DEPTH      = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_valid_i,
    input  logic [SIZE_MAT*WIDTH_DATA-1:0] wr_v_data_i,
    input  logic [SIZE_MAT*WIDTH_DATA-1:0] wr_h_data_i,
    input  logic                           wr_last_i,
    output logic                           wr_ready_o,
    input  logic                           read_en_i,
    output logic                           data_rdy_o,
    output logic [SIZE_MAT*WIDTH_DATA-1:0] v_bus_o,
    output logic [SIZE_MAT*WIDTH_DATA-1:0] h_bus_o,
    output logic                           burst_done_o,
    output logic                           underflow_err_o
);

    localparam int BW  = SIZE_MAT * WIDTH_DATA;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PCW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   mem_v [DEPTH];
    logic [BW-1:0]   mem_h [DEPTH];
    logic            mem_last [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_nxt, last_cnt;
    logic [PCW-1:0]  pop_cnt;
    logic            push, pop, head_last, burst_end;

    assign wr_ready_o = (count < CW'(DEPTH));
    assign push       = wr_valid_i && wr_ready_o;
    assign pop        = read_en_i && data_rdy_o;
    assign head_last  = mem_last[rd_ptr];
    assign burst_end  = pop && ((pop_cnt == PCW'(BURST_LEN - 1)) || head_last);
    assign count_nxt  = count + CW'(push) - CW'(pop);

    // Storage is deliberately left out of reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_v[wr_ptr]    <= wr_v_data_i;
            mem_h[wr_ptr]    <= wr_h_data_i;
            mem_last[wr_ptr] <= wr_last_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            last_cnt        <= '0;
            pop_cnt         <= '0;
            underflow_err_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            last_cnt <= last_cnt + CW'(push && wr_last_i) - CW'(pop && head_last);
            if (state != STREAM)
                pop_cnt <= '0;
            else if (pop)
                pop_cnt <= pop_cnt + 1'b1;
            if (read_en_i && !data_rdy_o)
                underflow_err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (count != '0) state_nxt = FILL;
            FILL:   if (count >= CW'(BURST_LEN) || last_cnt != '0) state_nxt = STREAM;
            STREAM: if (burst_end) state_nxt = (count_nxt == '0) ? IDLE : FILL;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_rdy_o   = (state == STREAM);
        burst_done_o = (state == STREAM) && burst_end;
        v_bus_o      = data_rdy_o ? mem_v[rd_ptr] : '0;
        h_bus_o      = data_rdy_o ? mem_h[rd_ptr] : '0;
    end

endmodule

// File: tb/tb_pa_feeder.sv
// Directed bench for pa_feeder: bursts, early last, full buffer, underflow, partial burst, mid-burst reset.
module tb_pa_feeder;

    localparam int SIZE_MAT   = 16;
    localparam int WIDTH_DATA = 16;
    localparam int BW         = SIZE_MAT * WIDTH_DATA;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid_i = 1'b0;
    logic [BW-1:0] wr_v_data_i = '0;
    logic [BW-1:0] wr_h_data_i = '0;
    logic          wr_last_i = 1'b0;
    logic          wr_ready_o;
    logic          read_en_i = 1'b0;
    logic          data_rdy_o;
    logic [BW-1:0] v_bus_o;
    logic [BW-1:0] h_bus_o;
    logic          burst_done_o;
    logic          underflow_err_o;

    int total = 0;
    int bad   = 0;

    pa_feeder #(.SIZE_MAT(SIZE_MAT), .WIDTH_DATA(WIDTH_DATA), .DEPTH(8), .BURST_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid_i(wr_valid_i), .wr_v_data_i(wr_v_data_i), .wr_h_data_i(wr_h_data_i),
        .wr_last_i(wr_last_i), .wr_ready_o(wr_ready_o),
        .read_en_i(read_en_i), .data_rdy_o(data_rdy_o),
        .v_bus_o(v_bus_o), .h_bus_o(h_bus_o),
        .burst_done_o(burst_done_o), .underflow_err_o(underflow_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] vec(input int n);
        return {SIZE_MAT{WIDTH_DATA'(n)}};
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int n, input logic last);
        wr_valid_i  = 1'b1;
        wr_v_data_i = vec(n);
        wr_h_data_i = vec(n + 100);
        wr_last_i   = last;
        tick();
        wr_valid_i  = 1'b0;
        wr_last_i   = 1'b0;
    endtask

    // Checks the presented entry and done pulse just before the popping edge.
    task automatic pop_expect(input int n, input logic done);
        read_en_i = 1'b1;
        #1;
        chk("pop_rdy", BW'(data_rdy_o), BW'(1));
        chk("pop_v", v_bus_o, vec(n));
        chk("pop_h", h_bus_o, vec(n + 100));
        chk("pop_done", BW'(burst_done_o), BW'(done));
        tick();
        read_en_i = 1'b0;
    endtask

    task automatic burst4(input int base);
        for (int i = 0; i < 4; i++) push_one(base + i, 1'b0);
        chk("b4_rdy_wait", BW'(data_rdy_o), BW'(0));
        tick();
        chk("b4_rdy_up", BW'(data_rdy_o), BW'(1));
        for (int i = 0; i < 4; i++) pop_expect(base + i, i == 3);
        chk("b4_rdy_end", BW'(data_rdy_o), BW'(0));
        chk("b4_vbus_zero", v_bus_o, '0);
        chk("b4_hbus_zero", h_bus_o, '0);
        chk("b4_count", BW'(dut.count), BW'(0));
        tick();
        chk("b4_idle", BW'(data_rdy_o), BW'(0));
    endtask

    initial begin
        #2;
        chk("rst_rdy", BW'(data_rdy_o), BW'(0));
        chk("rst_wr_ready", BW'(wr_ready_o), BW'(1));
        chk("rst_vbus", v_bus_o, '0);
        chk("rst_done", BW'(burst_done_o), BW'(0));
        chk("rst_uflow", BW'(underflow_err_o), BW'(0));
        tick();
        rst_n = 1'b1;

        // basic 4-entry burst right after reset release
        burst4(1);

        // early close with last flag
        push_one(5, 1'b0);
        push_one(6, 1'b1);
        tick();
        pop_expect(5, 1'b0);
        pop_expect(6, 1'b1);
        chk("last_count", BW'(dut.count), BW'(0));
        chk("last_rdy", BW'(data_rdy_o), BW'(0));

        // fill to DEPTH
        for (int i = 0; i < 8; i++) push_one(11 + i, 1'b0);
        chk("full_wr_ready", BW'(wr_ready_o), BW'(0));
        chk("full_count", BW'(dut.count), BW'(8));
        // push attempt while full together with a pop: push must be refused
        wr_valid_i = 1'b1; wr_v_data_i = vec(99); wr_h_data_i = vec(199);
        pop_expect(11, 1'b0);
        wr_valid_i = 1'b0;
        chk("after_pop_wr_ready", BW'(wr_ready_o), BW'(1));
        chk("after_pop_count", BW'(dut.count), BW'(7));
        // simultaneous push and pop at count 7
        wr_valid_i = 1'b1; wr_v_data_i = vec(19); wr_h_data_i = vec(119);
        pop_expect(12, 1'b0);
        wr_valid_i = 1'b0;
        chk("pushpop_count", BW'(dut.count), BW'(7));
        pop_expect(13, 1'b0);
        pop_expect(14, 1'b1);
        chk("full_b1_fill", BW'(data_rdy_o), BW'(0));
        tick();
        for (int i = 0; i < 4; i++) pop_expect(15 + i, i == 3);
        chk("full_b2_count", BW'(dut.count), BW'(1));
        push_one(20, 1'b1);
        tick();
        pop_expect(19, 1'b0);
        pop_expect(20, 1'b1);
        chk("full_drained", BW'(dut.count), BW'(0));
        tick();

        // underflow from IDLE
        read_en_i = 1'b1;
        #1;
        chk("uflow_pre", BW'(underflow_err_o), BW'(0));
        tick();
        read_en_i = 1'b0;
        chk("uflow_set", BW'(underflow_err_o), BW'(1));
        chk("uflow_count", BW'(dut.count), BW'(0));
        chk("uflow_rdy", BW'(data_rdy_o), BW'(0));
        tick(); tick();
        chk("uflow_sticky", BW'(underflow_err_o), BW'(1));

        // 6 entries: one full burst, then the remaining 2 wait for more
        for (int i = 0; i < 6; i++) push_one(21 + i, 1'b0);
        chk("p6_rdy", BW'(data_rdy_o), BW'(1));
        for (int i = 0; i < 4; i++) pop_expect(21 + i, i == 3);
        chk("p6_fill_rdy", BW'(data_rdy_o), BW'(0));
        chk("p6_fill_vbus", v_bus_o, '0);
        tick();
        chk("p6_still_fill", BW'(data_rdy_o), BW'(0));
        push_one(27, 1'b0);
        push_one(28, 1'b0);
        chk("p6_wait", BW'(data_rdy_o), BW'(0));
        tick();
        for (int i = 0; i < 4; i++) pop_expect(25 + i, i == 3);
        chk("p6_end_count", BW'(dut.count), BW'(0));
        chk("uflow_still", BW'(underflow_err_o), BW'(1));

        // reset in the middle of a burst
        for (int i = 0; i < 4; i++) push_one(31 + i, 1'b0);
        tick();
        pop_expect(31, 1'b0);
        pop_expect(32, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_rdy", BW'(data_rdy_o), BW'(0));
        chk("mrst_vbus", v_bus_o, '0);
        chk("mrst_hbus", h_bus_o, '0);
        chk("mrst_wr_ready", BW'(wr_ready_o), BW'(1));
        chk("mrst_count", BW'(dut.count), BW'(0));
        chk("mrst_uflow", BW'(underflow_err_o), BW'(0));
        tick();
        rst_n = 1'b1;
        burst4(41);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
